led_seq_ctrl: RTL and testbench
===============================

# led_seq_ctrl

LED pattern sequencer for the 6-LED bank on the Tang Nano 9K board. The block divides the 27 MHz system clock into a step tick and drives one of four LED patterns from that tick. A debounced user button selects the pattern by cycling through the modes. It sits between the board pins (`btn_n`, `led[5:0]`) and replaces free-running single-pattern LED logic.

## Interface
- `CLK_HZ`, 27_000_000, system clock frequency in Hz.
- `STEP_MS`, 500, pattern step period in ms; `STEP_CYC = (CLK_HZ/1000)*STEP_MS`, minimum 2.
- `DB_MS`, 20, button debounce time in ms; `DB_CYC = (CLK_HZ/1000)*DB_MS`, minimum 1.
- `AUTO_STEPS`, 12, steps per mode before auto-advance. Used only with `LED_SEQ_AUTO_EN`.
- `sys_clk`, in, 1, system clock. All logic is on its rising edge.
- `sys_rst_n`, in, 1, reset. One clock; reset is synchronous and active-low.
- `btn_n`, in, 1, asynchronous user button; 0 = pressed.
- `led`, out, 6, LED pins, registered; active-low (0 = lit).
- `mode`, out, 2, current mode, registered: 0 SHIFT, 1 BOUNCE, 2 BLINK, 3 COUNT.

## Operation
- Internal pattern `p[5:0]`: 1 = lit; `led` is always `~p`, registered.
- Reset (any edge with `sys_rst_n`=0, including mid-operation) sets:
  - `mode`=SHIFT, `p`=000001 (`led`=111110), step counter 0.
  - Bounce direction = up, debounce state = released, auto step count 0.
- Step counter counts 0..STEP_CYC-1, then wraps to 0. A tick occurs in the cycle where the counter equals STEP_CYC-1.
- On a tick, `p` advances according to the mode:
  - SHIFT: rotate left, `p={p[4:0],p[5]}`.
  - BOUNCE: one lit LED moves by one position. At bit 5 moving up, direction flips and bit 4 lights; at bit 0 moving down, direction flips and bit 1 lights. Sequence is 0,1,2,3,4,5,4,3,2,1,0,1…
  - BLINK: `p=~p`, alternating 111111 and 000000.
  - COUNT: `p=p+1` modulo 64; 63 wraps to 0.
- Button path:
  - 2-flop synchronizer feeds a debouncer with an accepted level.
  - The debounce counter increments while the synced level differs from the accepted level and clears when they match.
  - When the counter reaches DB_CYC-1, the accepted level flips.
  - A 1→0 flip of the accepted level is a press event; exactly one event per press. The next press requires the accepted level to return to 1 first.
- Press event → mode advances SHIFT→BOUNCE→BLINK→COUNT→SHIFT. On mode entry:
  - `p` loads the mode's initial value: SHIFT 000001, BOUNCE 000001 with direction up, BLINK 111111, COUNT 000000.
  - Step counter clears to 0 and the auto step count clears.
- Press event in the same cycle as a tick: the mode change wins and the tick is discarded.

## Timing
- `led` and `mode` change only on `sys_clk` edges and are glitch-free.
- Step latency: after reset release or mode entry, the first pattern change occurs STEP_CYC edges later. Subsequent changes occur every STEP_CYC edges.
- Button latency: `mode`/`led` update DB_CYC+2 edges after the first edge that samples `btn_n`=0, provided the low level is held throughout.
- Pulses on `btn_n` shorter than DB_CYC cycles after sync are ignored.
- Reset recovery: outputs hold reset values on the edge that samples `sys_rst_n`=1 and operate normally after that edge.

## Configuration
- `LED_SEQ_AUTO_EN` defined:
  - Count ticks in the current mode.
  - On the tick that makes the count equal AUTO_STEPS, advance the mode exactly as a press event would, instead of applying the step.
  - A button press still advances the mode and clears the count.
- `LED_SEQ_AUTO_EN` undefined: no auto-advance logic is present, AUTO_STEPS is unused, and the mode changes only on press events.

## Test plan
Simulation parameters: CLK_HZ=1000, STEP_MS=10 (STEP_CYC=10), DB_MS=3 (DB_CYC=3), AUTO_STEPS=4.
- Reset, then release with `btn_n`=1 → `led`=111110 and `mode`=0; `led`=111101 after 10 edges, 111011 after 20, and 111110 again after 60.
- Press (`btn_n`=0 for 10 cycles) → `mode`=1 exactly 5 edges after the first low sample, and `led`=111110. Lit LED index then steps 0,1,2,3,4,5,4,3,2,1,0 over ten ticks.
- 2-cycle low glitch on `btn_n` → `mode` unchanged. Then three clean presses from BOUNCE → modes 2, 3, 0:
  - BLINK `led` alternates 000000/111111.
  - COUNT `led` = `~p` through 0..63 and wraps to 0 on the 64th tick.
- Press timed so the press event lands on a tick cycle → mode advances, `p` equals the new mode's initial value, and the next step occurs 10 edges later.
- Assert `sys_rst_n`=0 for one cycle mid-COUNT, or mid-debounce with `btn_n` held low → next edge gives `led`=111110 and `mode`=0. A press still held after release needs a full DB_CYC+2 edges to register.
- With `LED_SEQ_AUTO_EN`, idle button → mode advances 0→1 on the 4th tick, i.e. 40 edges after reset. Without the macro, `mode` stays 0 for at least 200 edges.

Source files
------------

// File: rtl/led_seq_ctrl_if.sv
// Pin-level bundle for the LED sequencer: button input plus LED and mode outputs.
interface led_seq_ctrl_if;
   logic       btn_n;
   logic [5:0] led;
   logic [1:0] mode;

   modport master (output btn_n, input led, input mode);
   modport slave  (input btn_n, output led, output mode);
endinterface

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer (SHIFT/BOUNCE/BLINK/COUNT) stepped by a divided tick, mode cycled by a debounced button.
// Optional auto mode-advance every AUTO_STEPS ticks is enabled by defining LED_SEQ_AUTO_EN.
module led_seq_ctrl #(
   parameter int unsigned CLK_HZ     = 27_000_000,
   parameter int unsigned STEP_MS    = 500,
   parameter int unsigned DB_MS      = 20,
   parameter int unsigned AUTO_STEPS = 12
) (
   input  logic          sys_clk,
   input  logic          sys_rst_n,
   led_seq_ctrl_if.slave pins
);
   localparam int unsigned STEP_RAW = (CLK_HZ / 1000) * STEP_MS;
   localparam int unsigned STEP_CYC = (STEP_RAW < 2) ? 2 : STEP_RAW;
   localparam int unsigned DB_RAW   = (CLK_HZ / 1000) * DB_MS;
   localparam int unsigned DB_CYC   = (DB_RAW < 1) ? 1 : DB_RAW;
   localparam int unsigned STEP_W   = $clog2(STEP_CYC);
   localparam int unsigned DB_W     = $clog2(DB_CYC + 1);

   typedef enum logic [1:0] {SHIFT = 2'd0, BOUNCE = 2'd1, BLINK = 2'd2, COUNT = 2'd3} mode_t;

   mode_t             mode, mode_next;
   logic [5:0]        led, p, p_next;
   logic              dir, dir_next;   // 1 = lit LED moving toward bit 5
   logic              sync1, sync2, accepted;
   logic [DB_W-1:0]   db_cnt;
   logic [STEP_W-1:0] step_cnt;
   logic              db_done, press, tick, enter, auto_adv;

   if (AUTO_STEPS == 0) begin : g_auto_steps_check
      $error("AUTO_STEPS must be at least 1");
   end

   // Button synchronizer and debouncer; accepted level flips after DB_CYC stable cycles
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         sync1    <= 1'b1;
         sync2    <= 1'b1;
         accepted <= 1'b1;
         db_cnt   <= '0;
      end else begin
         sync1 <= pins.btn_n;
         sync2 <= sync1;
         if (sync2 == accepted) begin
            db_cnt <= '0;
         end else if (db_done) begin
            accepted <= sync2;
            db_cnt   <= '0;
         end else begin
            db_cnt <= db_cnt + DB_W'(1);
         end
      end
   end

   assign db_done = (sync2 != accepted) && (db_cnt == DB_W'(DB_CYC - 1));
   assign press   = db_done && accepted;
   assign tick    = (step_cnt == STEP_W'(STEP_CYC - 1));

`ifdef LED_SEQ_AUTO_EN
   localparam int unsigned AUTO_W = $clog2(AUTO_STEPS + 1);
   logic [AUTO_W-1:0] auto_cnt;

   // Ticks spent in the current mode; the AUTO_STEPS-th tick advances instead of stepping
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n || enter) auto_cnt <= '0;
      else if (tick)           auto_cnt <= auto_cnt + AUTO_W'(1);
   end

   assign auto_adv = tick && (auto_cnt == AUTO_W'(AUTO_STEPS - 1));
`else
   assign auto_adv = 1'b0;
`endif

   // Mode state register
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) mode <= SHIFT;
      else            mode <= mode_next;
   end

   // Mode next-state: a press (or auto-advance) moves to the next mode
   always_comb begin
      mode_next = mode;
      enter     = 1'b0;
      if (press || auto_adv) begin
         mode_next = mode_t'(mode + 2'd1);
         enter     = 1'b1;
      end
   end

   // Pattern next value; mode entry overrides a coincident tick
   always_comb begin
      p        = ~led;
      p_next   = p;
      dir_next = dir;
      if (enter) begin
         dir_next = 1'b1;
         case (mode_next)
            SHIFT, BOUNCE: p_next = 6'b000001;
            BLINK:         p_next = 6'b111111;
            default:       p_next = 6'b000000;
         endcase
      end else if (tick) begin
         case (mode)
            SHIFT:   p_next = {p[4:0], p[5]};
            BOUNCE: begin
               if (dir) begin
                  if (p[5]) begin
                     p_next   = 6'b010000;
                     dir_next = 1'b0;
                  end else begin
                     p_next = {p[4:0], 1'b0};
                  end
               end else begin
                  if (p[0]) begin
                     p_next   = 6'b000010;
                     dir_next = 1'b1;
                  end else begin
                     p_next = {1'b0, p[5:1]};
                  end
               end
            end
            BLINK:   p_next = ~p;
            default: p_next = p + 6'd1;
         endcase
      end
   end

   // Pattern, direction and step counter registers
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         led      <= 6'b111110;
         dir      <= 1'b1;
         step_cnt <= '0;
      end else begin
         led <= ~p_next;
         dir <= dir_next;
         if (enter || tick) step_cnt <= '0;
         else               step_cnt <= step_cnt + STEP_W'(1);
      end
   end

   assign pins.led  = led;
   assign pins.mode = mode;
endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl with CLK_HZ=1000, STEP_MS=10, DB_MS=3, AUTO_STEPS=4.
module tb_led_seq_ctrl;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   led_seq_ctrl_if bus ();

   led_seq_ctrl #(
      .CLK_HZ    (1000),
      .STEP_MS   (10),
      .DB_MS     (3),
      .AUTO_STEPS(4)
   ) dut (
      .sys_clk  (clk),
      .sys_rst_n(rst_n),
      .pins     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n rising edges, then settle 1 time unit past the last one
   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      bus.btn_n = 1'b1;
      edges(2);
      checks++; if (bus.led !== 6'b111110) begin errors++; $display("FAIL reset_led: got %b expected 111110", bus.led); end
      checks++; if (bus.mode !== 2'd0) begin errors++; $display("FAIL reset_mode: got %0d expected 0", bus.mode); end
      rst_n = 1'b1;
      edges(1);
      checks++; if (bus.led !== 6'b111110) begin errors++; $display("FAIL release_edge_led: got %b expected 111110", bus.led); end
      edges(8);
      checks++; if (bus.led !== 6'b111110) begin errors++; $display("FAIL shift_9: got %b expected 111110", bus.led); end
      edges(1);
      checks++; if (bus.led !== 6'b111101) begin errors++; $display("FAIL shift_10: got %b expected 111101", bus.led); end
      edges(10);
      checks++; if (bus.led !== 6'b111011) begin errors++; $display("FAIL shift_20: got %b expected 111011", bus.led); end
`ifndef LED_SEQ_AUTO_EN
      edges(40);
      checks++; if (bus.led !== 6'b111110) begin errors++; $display("FAIL shift_60: got %b expected 111110", bus.led); end
`endif
   endtask

   task automatic test_press;
      int exp_idx [10] = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0};
      logic [5:0] e;
      bus.btn_n = 1'b0;
      edges(4);
      checks++; if (bus.mode !== 2'd0) begin errors++; $display("FAIL press_early: mode %0d expected 0", bus.mode); end
      edges(1);
      checks++; if (bus.mode !== 2'd1) begin errors++; $display("FAIL press_mode: got %0d expected 1", bus.mode); end
      checks++; if (bus.led !== 6'b111110) begin errors++; $display("FAIL bounce_entry: got %b expected 111110", bus.led); end
      edges(5);
      bus.btn_n = 1'b1;
      edges(5);
      for (int i = 0; i < 10; i++) begin
         if (i != 0) edges(10);
         e = 6'b000001 << exp_idx[i];
         checks++; if (bus.led !== ~e) begin errors++; $display("FAIL bounce_step%0d: got %b expected %b", i, bus.led, ~e); end
      end
   endtask

   task automatic test_glitch;
      bus.btn_n = 1'b0;
      edges(2);
      bus.btn_n = 1'b1;
      edges(10);
      checks++; if (bus.mode !== 2'd1) begin errors++; $display("FAIL glitch_mode: got %0d expected 1", bus.mode); end
   endtask

   task automatic test_modes;
      logic [5:0] e;
      bus.btn_n = 1'b0;
      edges(5);
      checks++; if (bus.mode !== 2'd2) begin errors++; $display("FAIL blink_mode: got %0d expected 2", bus.mode); end
      checks++; if (bus.led !== 6'b000000) begin errors++; $display("FAIL blink_entry: got %b expected 000000", bus.led); end
      bus.btn_n = 1'b1;
      edges(5);
      edges(5);
      checks++; if (bus.led !== 6'b111111) begin errors++; $display("FAIL blink_t1: got %b expected 111111", bus.led); end
      edges(10);
      checks++; if (bus.led !== 6'b000000) begin errors++; $display("FAIL blink_t2: got %b expected 000000", bus.led); end
      edges(10);
      checks++; if (bus.led !== 6'b111111) begin errors++; $display("FAIL blink_t3: got %b expected 111111", bus.led); end

      bus.btn_n = 1'b0;
      edges(5);
      checks++; if (bus.mode !== 2'd3) begin errors++; $display("FAIL count_mode: got %0d expected 3", bus.mode); end
      checks++; if (bus.led !== 6'b111111) begin errors++; $display("FAIL count_entry: got %b expected 111111", bus.led); end
      bus.btn_n = 1'b1;
      edges(5);
      for (int k = 1; k <= 64; k++) begin
         edges((k == 1) ? 5 : 10);
         e = 6'(k);
         checks++; if (bus.led !== ~e) begin errors++; $display("FAIL count_t%0d: got %b expected %b", k, bus.led, ~e); end
      end

      bus.btn_n = 1'b0;
      edges(5);
      checks++; if (bus.mode !== 2'd0) begin errors++; $display("FAIL wrap_mode: got %0d expected 0", bus.mode); end
      checks++; if (bus.led !== 6'b111110) begin errors++; $display("FAIL shift_entry: got %b expected 111110", bus.led); end
      bus.btn_n = 1'b1;
      edges(5);
   endtask

   task automatic test_press_on_tick;
      // Five edges from first low sample lands the press on the SHIFT tick edge
      bus.btn_n = 1'b0;
      edges(5);
      checks++; if (bus.mode !== 2'd1) begin errors++; $display("FAIL tick_press_mode: got %0d expected 1", bus.mode); end
      checks++; if (bus.led !== 6'b111110) begin errors++; $display("FAIL tick_press_led: got %b expected 111110", bus.led); end
      bus.btn_n = 1'b1;
      edges(9);
      checks++; if (bus.led !== 6'b111110) begin errors++; $display("FAIL tick_press_9: got %b expected 111110", bus.led); end
      edges(1);
      checks++; if (bus.led !== 6'b111101) begin errors++; $display("FAIL tick_press_10: got %b expected 111101", bus.led); end
   endtask

   task automatic test_reset_mid;
      repeat (2) begin
         bus.btn_n = 1'b0;
         edges(5);
         bus.btn_n = 1'b1;
         edges(5);
      end
      checks++; if (bus.mode !== 2'd3) begin errors++; $display("FAIL mid_pre_mode: got %0d expected 3", bus.mode); end
      edges(25);
      rst_n = 1'b0;
      edges(1);
      checks++; if (bus.led !== 6'b111110) begin errors++; $display("FAIL mid_count_led: got %b expected 111110", bus.led); end
      checks++; if (bus.mode !== 2'd0) begin errors++; $display("FAIL mid_count_mode: got %0d expected 0", bus.mode); end
      rst_n = 1'b1;
      edges(3);
      bus.btn_n = 1'b0;
      edges(3);
      rst_n = 1'b0;
      edges(1);
      checks++; if (bus.led !== 6'b111110) begin errors++; $display("FAIL mid_db_led: got %b expected 111110", bus.led); end
      checks++; if (bus.mode !== 2'd0) begin errors++; $display("FAIL mid_db_mode: got %0d expected 0", bus.mode); end
      rst_n = 1'b1;
      edges(4);
      checks++; if (bus.mode !== 2'd0) begin errors++; $display("FAIL held_press_early: got %0d expected 0", bus.mode); end
      edges(1);
      checks++; if (bus.mode !== 2'd1) begin errors++; $display("FAIL held_press_mode: got %0d expected 1", bus.mode); end
      checks++; if (bus.led !== 6'b111110) begin errors++; $display("FAIL held_press_led: got %b expected 111110", bus.led); end
      bus.btn_n = 1'b1;
      edges(5);
   endtask

   task automatic test_auto;
      rst_n = 1'b0;
      bus.btn_n = 1'b1;
      edges(2);
      rst_n = 1'b1;
`ifdef LED_SEQ_AUTO_EN
      edges(39);
      checks++; if (bus.mode !== 2'd0) begin errors++; $display("FAIL auto_39_mode: got %0d expected 0", bus.mode); end
      checks++; if (bus.led !== 6'b110111) begin errors++; $display("FAIL auto_39_led: got %b expected 110111", bus.led); end
      edges(1);
      checks++; if (bus.mode !== 2'd1) begin errors++; $display("FAIL auto_40_mode: got %0d expected 1", bus.mode); end
      checks++; if (bus.led !== 6'b111110) begin errors++; $display("FAIL auto_40_led: got %b expected 111110", bus.led); end
`else
      for (int i = 1; i <= 20; i++) begin
         edges(10);
         checks++; if (bus.mode !== 2'd0) begin errors++; $display("FAIL no_auto_%0d: mode %0d expected 0", i * 10, bus.mode); end
      end
      checks++; if (bus.led !== 6'b111011) begin errors++; $display("FAIL no_auto_led: got %b expected 111011", bus.led); end
`endif
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      bus.btn_n = 1'b1;
      test_reset();
`ifndef LED_SEQ_AUTO_EN
      test_press();
      test_glitch();
      test_modes();
      test_press_on_tick();
      test_reset_mid();
`endif
      test_auto();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
